// File: rtl/menu_text_reader.sv
// menu_text_reader
// Read-side engine for the 2 KB OSD menu RAM. For each requested scanline it
// reads COLS character codes from the text map, reads the matching font row of
// each glyph, and streams 256 one-bit pixels (LSB of each glyph byte first) to
// the overlay mixer over a valid/ready handshake.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   line_start, line    : one-cycle scanline request (dropped while busy)
//   busy, line_done     : line in progress / one-cycle completion pulse
//   ram_ce, ram_ad      : menu RAM read port request
//   ram_dout            : read data, valid the cycle after ram_ce
//   pix_valid/pix_ready : pixel handshake
//   pix, pix_x, pix_last: pixel value, column, last-column flag
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for line_start, latches line
// FETCH  | walking columns, running the char/glyph fetch pipeline
// DRAIN  | all fetches issued and returned, shifting out the remainder
// DONE   | line_done pulse; a new line_start is accepted here as well

module menu_text_reader #(
    parameter int          COLS      = 32,
    parameter int          ROWS      = 28,
    parameter logic [10:0] TEXT_BASE = 11'h000,
    parameter logic [10:0] FONT_BASE = 11'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  line,
    output logic        busy,
    output logic        line_done,
    output logic        ram_ce,
    output logic [10:0] ram_ad,
    input  logic [7:0]  ram_dout,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix,
    output logic [7:0]  pix_x,
    output logic        pix_last
);

    localparam int CW = $clog2(COLS + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      line_q, line_d;
    logic            blank_q, blank_d;
    logic [CW-1:0]   col_q, col_d;
    logic            g_pend_q, g_pend_d;   // char read last cycle: glyph read now
    logic            d_pend_q, d_pend_d;   // glyph read last cycle: glyph on ram_dout now
    logic            inv_q, inv_d;
    logic [7:0]      sh_q, sh_d;
    logic [3:0]      sh_cnt_q, sh_cnt_d;   // pixels left in the shifter
    logic [7:0]      hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [7:0]      pix_x_q, pix_x_d;

    logic            accept;
    logic            reload;
    logic            issue;
    logic            start;
    logic [7:0]      new_byte;

    always_comb begin
        busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
        line_done = (state_q == S_DONE);
        pix_valid = busy && (sh_cnt_q != 4'd0);
        pix       = sh_q[0];
        pix_x     = pix_x_q;
        pix_last  = pix_valid && (pix_x_q == 8'hFF);
        accept    = pix_valid && pix_ready;

        // The shifter takes a new byte when it is empty or its last pixel leaves now.
        reload    = busy && ((sh_cnt_q == 4'd0) || (accept && (sh_cnt_q == 4'd1)));

        // One fetch in flight at a time, and only if its result has somewhere to go.
        issue     = (state_q == S_FETCH) && (col_q < CW'(COLS)) && !g_pend_q && !d_pend_q
                    && (!hold_full_q || reload);

        // Blank lines run the same pipeline timing but never touch the RAM.
        new_byte  = blank_q ? 8'h00 : (ram_dout ^ {8{inv_q}});

        ram_ce = 1'b0;
        ram_ad = 11'h000;
        if (!blank_q) begin
            if (issue) begin
                ram_ce = 1'b1;
                ram_ad = TEXT_BASE + 11'({line_q[7:3], 5'd0}) + 11'(col_q);
            end else if (g_pend_q) begin
                ram_ce = 1'b1;
                ram_ad = FONT_BASE + 11'({ram_dout[6:0], line_q[2:0]});
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        blank_d     = blank_q;
        col_d       = col_q;
        g_pend_d    = issue;
        d_pend_d    = g_pend_q;
        inv_d       = inv_q;
        sh_d        = sh_q;
        sh_cnt_d    = sh_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        pix_x_d     = pix_x_q;
        start       = 1'b0;

        if (issue) begin
            col_d = col_q + CW'(1);
        end
        if (g_pend_q) begin
            inv_d = ram_dout[7];
        end

        if (accept) begin
            sh_d     = sh_q >> 1;
            sh_cnt_d = sh_cnt_q - 4'd1;
            if (pix_x_q != 8'hFF) begin
                pix_x_d = pix_x_q + 8'd1;
            end
        end

        if (reload) begin
            if (hold_full_q) begin
                sh_d        = hold_q;
                sh_cnt_d    = 4'd8;
                hold_full_d = 1'b0;
            end else if (d_pend_q) begin
                sh_d     = new_byte;
                sh_cnt_d = 4'd8;
            end
        end

        // A returning glyph that did not go straight into the shifter is parked.
        if (d_pend_q && !(reload && !hold_full_q)) begin
            hold_d      = new_byte;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    start = 1'b1;
                end
            end
            S_FETCH: begin
                if (accept && pix_last) begin
                    state_d = S_DONE;
                end else if ((col_q == CW'(COLS)) && !g_pend_q && !d_pend_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (accept && pix_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (line_start) begin
                    start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            state_d     = S_FETCH;
            line_d      = line;
            blank_d     = ({1'b0, line} >= 9'(8 * ROWS));
            col_d       = '0;
            g_pend_d    = 1'b0;
            d_pend_d    = 1'b0;
            inv_d       = 1'b0;
            sh_d        = 8'h00;
            sh_cnt_d    = 4'd0;
            hold_d      = 8'h00;
            hold_full_d = 1'b0;
            pix_x_d     = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            line_q      <= 8'h00;
            blank_q     <= 1'b0;
            col_q       <= '0;
            g_pend_q    <= 1'b0;
            d_pend_q    <= 1'b0;
            inv_q       <= 1'b0;
            sh_q        <= 8'h00;
            sh_cnt_q    <= 4'd0;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            pix_x_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            line_q      <= line_d;
            blank_q     <= blank_d;
            col_q       <= col_d;
            g_pend_q    <= g_pend_d;
            d_pend_q    <= d_pend_d;
            inv_q       <= inv_d;
            sh_q        <= sh_d;
            sh_cnt_q    <= sh_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            pix_x_q     <= pix_x_d;
        end
    end

endmodule

// File: tb/tb_menu_text_reader.sv
// Bench for menu_text_reader: behavioural RAM with 1-cycle read latency, a
// pixel scoreboard filled from a reference model when a line is requested,
// a table of scanline vectors, and hand sequences for the multi-cycle cases.

module tb_menu_text_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [7:0]  line = 8'h00;
    logic        busy, line_done, ram_ce, pix_valid, pix, pix_last;
    logic [10:0] ram_ad;
    logic [7:0]  ram_dout = 8'h00;
    logic        pix_ready = 1'b0;
    logic [7:0]  pix_x;

    menu_text_reader dut (
        .clk       (clk),
        .reset     (reset),
        .line_start(line_start),
        .line      (line),
        .busy      (busy),
        .line_done (line_done),
        .ram_ce    (ram_ce),
        .ram_ad    (ram_ad),
        .ram_dout  (ram_dout),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix       (pix),
        .pix_x     (pix_x),
        .pix_last  (pix_last)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:2047];

    always @(posedge clk) begin
        if (ram_ce) ram_dout <= mem[ram_ad];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got nothing expected event", nm);
    endtask

    // Reference model of one pixel.
    function automatic logic exp_pix(input logic [7:0] ln, input int x);
        logic [7:0]  code;
        logic [7:0]  g;
        logic [10:0] a;
        if (int'(ln) >= 224) return 1'b0;
        a    = 11'((int'(ln) / 8) * 32 + x / 8);
        code = mem[a];
        a    = 11'(1024 + int'(code[6:0]) * 8 + int'(ln) % 8);
        g    = mem[a];
        if (code[7]) g = ~g;
        return g[x % 8];
    endfunction

    typedef struct {
        logic [7:0] x;
        logic       p;
    } px_t;
    px_t sb[$];

    task automatic push_line(input logic [7:0] ln);
        px_t e;
        for (int x = 0; x < 256; x++) begin
            e.x = 8'(x);
            e.p = exp_pix(ln, x);
            sb.push_back(e);
        end
    endtask

    // Monitor state
    int          cyc = 0;
    int          t_start = -1000;
    int          first_valid = -1;
    int          last_cyc = -1;
    int          done_cyc = -1;
    int          nxfer = 0;
    int          ndone = 0;
    int          nd_start = 0;
    logic [10:0] ad1, ad2;
    logic        ce1, ce2, busy1;
    logic        ce_seen = 1'b0;
    logic [7:0]  byte0 = 8'h00;
    logic        stall_prev = 1'b0;
    logic        prev_pix;
    logic [7:0]  prev_x;

    always @(negedge clk) begin
        px_t e;
        cyc++;
        if (line_done) begin
            ndone++;
            done_cyc = cyc;
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("valid_at_done", {31'd0, pix_valid}, 32'd0);
        end
        if (line_start && !busy && !reset) begin
            t_start     = cyc;
            first_valid = -1;
            last_cyc    = -1;
            nxfer       = 0;
            ce_seen     = 1'b0;
            byte0       = 8'h00;
        end
        if (cyc == t_start + 1) begin
            ad1 = ram_ad; ce1 = ram_ce; busy1 = busy;
        end
        if (cyc == t_start + 2) begin
            ad2 = ram_ad; ce2 = ram_ce;
        end
        if (ram_ce) ce_seen = 1'b1;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", {31'd0, pix_valid}, 32'd1);
                chk("stall_pix", {31'd0, pix}, {31'd0, prev_pix});
                chk("stall_x", {24'd0, pix_x}, {24'd0, prev_x});
            end
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (pix_valid && pix_ready) begin
                if (sb.size() == 0) begin
                    fail_now("sb_underflow");
                end else begin
                    e = sb.pop_front();
                    chk("pix_x", {24'd0, pix_x}, {24'd0, e.x});
                    chk("pix", {31'd0, pix}, {31'd0, e.p});
                    chk("pix_last", {31'd0, pix_last}, {31'd0, (e.x == 8'hFF)});
                end
                if (pix_x < 8'd8) byte0[pix_x[2:0]] = pix;
                if (pix_last) last_cyc = cyc;
                nxfer++;
            end
            stall_prev = pix_valid && !pix_ready;
            prev_pix   = pix;
            prev_x     = pix_x;
        end
    end

    typedef struct {
        logic [7:0]  ln;
        int          pct;
        logic [7:0]  b0;
        logic [10:0] ad1;
        logic [10:0] ad2;
        bit          blank;
    } vec_t;
    vec_t vecs[7];

    task automatic start_line(input logic [7:0] ln, input int pct);
        line       = ln;
        line_start = 1'b1;
        pix_ready  = (pct >= 100);
        push_line(ln);
        nd_start   = ndone;
        @(posedge clk); #1;
        line_start = 1'b0;
    endtask

    task automatic wait_line(input int pct, input bit drop, input bit chain_en, input logic [7:0] chain_ln);
        int nd0;
        bit ok;
        nd0 = ndone;
        ok  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (ndone != nd0) begin
                ok = 1'b1;
                break;
            end
            line_start = 1'b0;
            if (chain_en && line_done) begin
                line_start = 1'b1;
                line       = chain_ln;
                push_line(chain_ln);
                nd_start   = ndone + 1;
            end else if (drop && k == 40) begin
                line_start = 1'b1;
                line       = 8'd8;
            end
            pix_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            @(posedge clk); #1;
        end
        line_start = 1'b0;
        if (!ok) fail_now("line_done_timeout");
    endtask

    task automatic check_line(input vec_t v);
        repeat (5) @(posedge clk);
        #1;
        chk("done_count", 32'(ndone - nd_start), 32'd1);
        chk("xfers", 32'(nxfer), 32'd256);
        chk("sb_left", 32'(sb.size()), 32'd0);
        chk("byte0", {24'd0, byte0}, {24'd0, v.b0});
        chk("busy_T1", {31'd0, busy1}, 32'd1);
        if (v.blank) begin
            chk("ce_blank", {31'd0, ce_seen}, 32'd0);
        end else begin
            chk("char_ad", {21'd0, ad1}, {21'd0, v.ad1});
            chk("char_ce", {31'd0, ce1}, 32'd1);
            chk("glyph_ad", {21'd0, ad2}, {21'd0, v.ad2});
            chk("glyph_ce", {31'd0, ce2}, 32'd1);
        end
        if (v.pct >= 100) begin
            chk("first_valid", 32'(first_valid - t_start), 32'd4);
            chk("last_at", 32'(last_cyc - t_start), 32'd259);
            chk("done_at", 32'(done_cyc - t_start), 32'd260);
        end
    endtask

    initial begin
        int  nd0;
        bit  found;
        for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
        mem[11'h000] = 8'h41;  mem[11'h608] = 8'h0C;
        mem[11'h020] = 8'hC1;  mem[11'h021] = 8'hC1;  mem[11'h609] = 8'h1E;
        mem[11'h360] = 8'h05;  mem[11'h42F] = 8'hA5;
        mem[11'h180] = 8'h82;  mem[11'h414] = 8'h3C;

        vecs[0] = '{8'd0,   100, 8'h0C, 11'h000, 11'h608, 1'b0};
        vecs[1] = '{8'd9,   100, 8'hE1, 11'h020, 11'h609, 1'b0};
        vecs[2] = '{8'd0,   50,  8'h0C, 11'h000, 11'h608, 1'b0};
        vecs[3] = '{8'd230, 100, 8'h00, 11'h000, 11'h000, 1'b1};
        vecs[4] = '{8'd223, 100, 8'hA5, 11'h360, 11'h42F, 1'b0};
        vecs[5] = '{8'd224, 30,  8'h00, 11'h000, 11'h000, 1'b1};
        vecs[6] = '{8'd100, 70,  8'hC3, 11'h180, 11'h414, 1'b0};

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'({busy, line_done, ram_ce, ram_ad, pix_valid, pix, pix_x, pix_last}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            start_line(vecs[i].ln, vecs[i].pct);
            wait_line(vecs[i].pct, 1'b0, 1'b0, 8'd0);
            check_line(vecs[i]);
        end

        // Request while busy is dropped.
        start_line(8'd0, 100);
        wait_line(100, 1'b1, 1'b0, 8'd0);
        check_line(vecs[0]);

        // Back-to-back: new request in the line_done cycle.
        start_line(8'd0, 100);
        wait_line(100, 1'b0, 1'b1, 8'd9);
        wait_line(100, 1'b0, 1'b0, 8'd0);
        check_line(vecs[1]);

        // Reset mid-line.
        start_line(8'd0, 100);
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (pix_valid && pix_x == 8'd100) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!found) fail_now("reach_x100_timeout");
        nd0   = ndone;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_mid_outputs", 32'({busy, line_done, ram_ce, ram_ad, pix_valid, pix, pix_x, pix_last}), 32'd0);
        reset = 1'b0;
        sb.delete();
        repeat (300) @(posedge clk);
        #1;
        chk("no_done_after_abort", 32'(ndone), 32'(nd0));
        start_line(8'd0, 100);
        wait_line(100, 1'b0, 1'b0, 8'd0);
        check_line(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
